// File: rtl/arbitrated_stream_mux_pkg.sv
// Shared types for the arbitrated stream mux: arbiter state encoding and channel-index width.
package arbitrated_stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitrated_stream_mux_picker.sv
// Rotating-priority picker: one-hot grant to the first requester at or after pointer, wrapping.
module rotating_priority_picker
  import arbitrated_stream_mux_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0]             requests,
  input  logic [chan_width(SIZE)-1:0] pointer,
  output logic [SIZE-1:0]             grant
);

  logic [2*SIZE-1:0] doubled;
  logic [SIZE-1:0]   rotated;
  logic [SIZE-1:0]   lowest;

  // Rotate so the pointer channel sits at bit 0, isolate the lowest set bit, rotate back.
  assign doubled = {requests, requests};
  assign rotated = SIZE'(doubled >> pointer);
  assign lowest  = rotated & (~rotated + SIZE'(1));
  assign grant   = SIZE'(({lowest, lowest} << pointer) >> SIZE);

endmodule

// File: rtl/arbitrated_stream_mux.sv
// N-to-1 stream mux with rotating-priority arbitration and a one-deep registered output.
// Define ARBITRATED_STREAM_MUX_PACKET_LOCK_EN to hold the grant for a whole packet.
module arbitrated_stream_mux
  import arbitrated_stream_mux_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [SIZE-1:0]             in_valid,
  output logic [SIZE-1:0]             in_ready,
  input  logic [SIZE*WIDTH-1:0]       in_data,
  input  logic [SIZE-1:0]             in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_last,
  output logic [chan_width(SIZE)-1:0] out_channel
);

  localparam int CW = chan_width(SIZE);

  logic [CW-1:0]    pointer;
  logic [CW-1:0]    pointer_next;
  logic [SIZE-1:0]  pick_grant;
  logic [SIZE-1:0]  grant;
  logic             can_load;
  logic             accept;
  logic [CW-1:0]    sel_ch;
  logic [CW-1:0]    sel_ch_wrap;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  rotating_priority_picker #(
    .SIZE(SIZE)
  ) u_picker (
    .requests(in_valid),
    .pointer (pointer),
    .grant   (pick_grant)
  );

  assign can_load = !out_valid || out_ready;
  assign in_ready = reset ? '0 : (grant & {SIZE{can_load}});
  assign accept   = |(in_ready & in_valid);

  // Grant is one-hot or zero, so a plain AND-OR reduction selects the beat.
  always_comb begin
    sel_ch   = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      sel_ch   = sel_ch | (CW'(i) & {CW{grant[i]}});
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
      sel_last = sel_last | (in_last[i] & grant[i]);
    end
  end

  assign sel_ch_wrap = (sel_ch == CW'(SIZE - 1)) ? '0 : sel_ch + CW'(1);

`ifdef ARBITRATED_STREAM_MUX_PACKET_LOCK_EN
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] lock_channel;
  logic [CW-1:0] lock_next;

  assign grant = (state == LOCKED) ? (SIZE'(1) << lock_channel) : pick_grant;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      lock_channel <= '0;
    end else begin
      state        <= state_next;
      lock_channel <= lock_next;
    end
  end

  // A non-final beat in IDLE locks onto its channel; the final beat releases and rotates.
  always_comb begin
    state_next   = state;
    lock_next    = lock_channel;
    pointer_next = pointer;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (sel_last) begin
            pointer_next = sel_ch_wrap;
          end else begin
            state_next = LOCKED;
            lock_next  = sel_ch;
          end
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_next   = IDLE;
          pointer_next = sel_ch_wrap;
        end
      end
      default: state_next = IDLE;
    endcase
  end
`else
  assign grant = pick_grant;

  always_comb begin
    pointer_next = pointer;
    if (accept) begin
      pointer_next = sel_ch_wrap;
    end
  end
`endif

  // Output register stage: load on accept, otherwise drain when downstream takes the beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      pointer     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_channel <= '0;
    end else begin
      pointer <= pointer_next;
      if (accept) begin
        out_valid   <= 1'b1;
        out_data    <= sel_data;
        out_last    <= sel_last;
        out_channel <= sel_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbitrated_stream_mux.sv
// Scoreboard bench for arbitrated_stream_mux: directed scenarios plus random traffic against a
// queue-based reference model. Follows ARBITRATED_STREAM_MUX_PACKET_LOCK_EN like the design.
module tb_arbitrated_stream_mux;

  localparam int SIZE  = 4;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(SIZE);
`ifdef ARBITRATED_STREAM_MUX_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic [CW-1:0]    ch;
  } beat_t;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [SIZE-1:0]       in_valid = '0;
  logic [SIZE-1:0]       in_ready;
  logic [SIZE*WIDTH-1:0] in_data = '0;
  logic [SIZE-1:0]       in_last = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [CW-1:0]         out_channel;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t exp_q[$];

  // Reference model state: served-next pointer, lock, and whether the output slot holds a beat.
  int m_ptr    = 0;
  bit m_locked = 1'b0;
  int m_lock   = 0;
  bit m_full   = 1'b0;

  arbitrated_stream_mux #(
    .SIZE (SIZE),
    .WIDTH(WIDTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_channel(out_channel)
  );

  always #5 clock = ~clock;

  task automatic cycle(input logic [SIZE-1:0] v, input logic [SIZE-1:0] l,
                       input logic [SIZE*WIDTH-1:0] d, input logic r, input logic rst);
    logic [SIZE-1:0] exp_grant;
    logic [SIZE-1:0] exp_ready;
    bit              found;
    bit              acc;
    int              ch;
    beat_t           b;
    @(negedge clock);
    in_valid  = v;
    in_last   = l;
    in_data   = d;
    out_ready = r;
    reset     = rst;
    #1;
    if (rst) begin
      vectors++;
      if (in_ready !== '0) begin
        miscompares++;
        $display("FAIL ready_in_reset: got %b want 0000", in_ready);
      end
      m_ptr = 0; m_locked = 1'b0; m_lock = 0; m_full = 1'b0;
      exp_q.delete();
    end else begin
      exp_grant = '0;
      found     = 1'b0;
      if (LOCK && m_locked) begin
        exp_grant = SIZE'(1) << m_lock;
      end else begin
        for (int k = 0; k < SIZE; k++)
          for (int c = 0; c < SIZE; c++)
            if (!found && c == (m_ptr + k) % SIZE && v[c]) begin
              exp_grant[c] = 1'b1;
              found = 1'b1;
            end
      end
      exp_ready = (!m_full || r) ? exp_grant : '0;
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL in_ready @%0t: got %b want %b", $time, in_ready, exp_ready);
      end
      vectors++;
      if (out_valid !== m_full) begin
        miscompares++;
        $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, m_full);
      end
      acc = 1'b0;
      ch  = 0;
      for (int c = 0; c < SIZE; c++)
        if (exp_ready[c] && v[c]) begin
          acc = 1'b1;
          ch  = c;
          b.data = d[c*WIDTH +: WIDTH];
          b.last = l[c];
          b.ch   = CW'(c);
        end
      if (acc) begin
        exp_q.push_back(b);
        if (LOCK && !l[ch]) begin
          m_locked = 1'b1;
          m_lock   = ch;
        end else begin
          m_locked = 1'b0;
          m_ptr    = (ch + 1) % SIZE;
        end
      end
      m_full = acc || (m_full && !r);
    end
  endtask

  function automatic logic [SIZE*WIDTH-1:0] rnd_data();
    return (SIZE*WIDTH)'($urandom);
  endfunction

  // Monitor: the beat on the output must match the oldest expected beat; pop when it drains.
  always @(negedge clock) begin
    #2;
    if (!reset && out_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat @%0t: got ch%0d data %h", $time, out_channel, out_data);
      end else begin
        if ({out_data, out_last, out_channel} !== exp_q[0]) begin
          miscompares++;
          $display("FAIL beat @%0t: got d=%h l=%b ch=%0d want d=%h l=%b ch=%0d", $time,
                   out_data, out_last, out_channel, exp_q[0].data, exp_q[0].last, exp_q[0].ch);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // Round robin over all channels with single-beat packets.
    repeat (2) cycle('0, '0, '0, 1'b1, 1'b1);
    repeat (6) cycle(4'b1111, 4'b1111, rnd_data(), 1'b1, 1'b0);

    // Three-beat packet on ch1 while ch2 keeps requesting.
    repeat (2) cycle('0, '0, '0, 1'b1, 1'b1);
    repeat (2) cycle(4'b0110, 4'b0000, rnd_data(), 1'b1, 1'b0);
    cycle(4'b0110, 4'b0010, rnd_data(), 1'b1, 1'b0);
    repeat (2) cycle(4'b0100, 4'b0100, rnd_data(), 1'b1, 1'b0);

    // Backpressure with 8'hA5 held in the output register.
    cycle(4'b0001, 4'b0001, {24'h123456, 8'hA5}, 1'b1, 1'b0);
    repeat (5) cycle(4'b0011, 4'b0011, rnd_data(), 1'b0, 1'b0);
    repeat (2) cycle(4'b0011, 4'b0011, rnd_data(), 1'b1, 1'b0);

    // Packet on ch0 whose valid drops for three cycles while ch3 requests.
    repeat (2) cycle('0, '0, '0, 1'b1, 1'b1);
    cycle(4'b0001, 4'b0000, rnd_data(), 1'b1, 1'b0);
    repeat (3) cycle(4'b1000, 4'b0000, rnd_data(), 1'b1, 1'b0);
    cycle(4'b1001, 4'b0001, rnd_data(), 1'b1, 1'b0);
    repeat (2) cycle(4'b1000, 4'b1000, rnd_data(), 1'b1, 1'b0);

    // Reset in the middle of a ch2 packet, then ch2 alone.
    repeat (2) cycle(4'b0100, 4'b0000, rnd_data(), 1'b1, 1'b0);
    cycle(4'b0100, 4'b0000, rnd_data(), 1'b1, 1'b1);
    repeat (2) cycle(4'b0100, 4'b0100, rnd_data(), 1'b1, 1'b0);

    // Two channels streaming non-final beats.
    repeat (2) cycle('0, '0, '0, 1'b1, 1'b1);
    repeat (6) cycle(4'b0011, 4'b0000, rnd_data(), 1'b1, 1'b0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++)
      cycle(SIZE'($urandom), ($urandom_range(0, 2) == 0) ? SIZE'($urandom) : '0, rnd_data(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);

    // Drain: release any lock by offering last on every channel, then idle.
    repeat (8) cycle(4'b1111, 4'b1111, rnd_data(), 1'b1, 1'b0);
    repeat (4) cycle('0, '0, '0, 1'b1, 1'b0);
    @(negedge clock);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d beats outstanding want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arbitrated_stream_mux.md
ARBITRATED_STREAM_MUX -- requirements
Module: arbitrated_stream_mux

Interface
REQ-001 SHALL have parameter SIZE, default 4, number of upstream channels (>=2).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per beat.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  SIZE  per-channel beat valid.
REQ-006 SHALL have port in_ready  output  SIZE  per-channel beat accepted.
REQ-007 SHALL have port in_data  input  SIZE*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last  input  SIZE  per-channel end-of-packet marker.
REQ-009 SHALL have port out_valid  output  1  registered output beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port out_data  output  WIDTH  registered beat data.
REQ-012 SHALL have port out_last  output  1  registered end-of-packet marker.
REQ-013 SHALL have port out_channel  output  $clog2(SIZE)  index of the source channel of the current output beat.

Function
REQ-014 Handshake: transfer on a channel when valid and ready are both high in the same cycle; valid SHALL NOT depend on ready.
REQ-015 One-deep output register; can_load = !out_valid | out_ready; accepted beat appears on out_* the next cycle (latency 1).
REQ-016 in_ready[i] = grant[i] & can_load; at most one bit of in_ready high per cycle (one-hot or zero).
REQ-017 Arbitration: rotating priority; search starts at channel (pointer) and wraps modulo SIZE; pointer = last served channel + 1, wrapping from SIZE-1 to 0.
REQ-018 State machine: IDLE (free arbitration) and LOCKED (grant held on lock_channel).
REQ-019 IDLE: grant = rotating-priority pick among in_valid; on an accepted beat with in_last=0 -> LOCKED, lock_channel = that channel; with in_last=1 -> stay IDLE, pointer advances.
REQ-020 LOCKED: grant = one-hot(lock_channel) regardless of other requests; accepted beat with in_last=1 -> IDLE, pointer = lock_channel+1.
REQ-021 Locked channel dropping in_valid mid-packet: grant SHALL stay locked; other channels wait (no preemption).
REQ-022 Output backpressure: out_valid, out_data, out_last, out_channel SHALL hold stable while out_valid & !out_ready.
REQ-023 Simultaneous output drain and load in one cycle: new beat replaces old; no bubble, no loss.
REQ-024 No request in IDLE: grant all zero, pointer unchanged.

Reset
REQ-025 On reset: state IDLE, pointer 0, lock_channel 0, out_valid 0, out_data 0, out_last 0, out_channel 0.
REQ-026 Reset mid-packet SHALL abandon the packet; no partial-packet beat is emitted after reset deasserts.
REQ-027 in_ready SHALL be all zero while reset is high.

Configuration
REQ-028 Macro ARBITRATED_STREAM_MUX_PACKET_LOCK_EN defined: behaviour per REQ-018..021 (packet-atomic grants).
REQ-029 Macro undefined: no LOCKED state; re-arbitration every beat, pointer advances after every accepted beat; in_last passed through to out_last only.

Structure
REQ-030 Shared package arbitrated_stream_mux_pkg SHALL hold the state enum (IDLE, LOCKED) and the channel-index width function.
REQ-031 Rotating-priority selection SHALL be a sub-module named rotating_priority_picker (inputs requests, pointer; output one-hot grant).
REQ-032 Data select SHALL be a one-hot AND-OR mux over in_data, no priority chain.

Verification
REQ-033 SIZE=4, lock on: in_valid=4'b1111, all in_last=1, out_ready=1 -> out_channel sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 Lock on: ch1 sends 3-beat packet (last on beat 3) while ch2 valid -> beats 1,1,1 then ch2; in_ready[2]=0 throughout ch1's packet.
REQ-035 out_ready=0 for 5 cycles with out_valid=1, data 8'hA5 -> out_data held 8'hA5, all in_ready 0; out_ready=1 -> next beat loaded same cycle.
REQ-036 Lock on: ch0 in packet, in_valid[0] drops 3 cycles, ch3 valid -> no ch3 grant until ch0 last accepted.
REQ-037 Assert reset mid-packet of ch2 -> next cycle out_valid=0, pointer 0; with in_valid=4'b0100 after reset, ch2 granted in IDLE.
REQ-038 Lock off: ch0 and ch1 both valid with in_last=0 -> output alternates 0,1,0,1.
